// File: rtl/crc_frame_checker.sv
// Serial CRC frame checker: shifts a payload through an MSB-first CRC register,
// then compares the computed CRC against the WIDTH received trailer bits.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   cfg_poly_data/cfg_poly_load   serial polynomial config (MSB first)
//   cfg_init_data/cfg_init_load   serial init-value config (MSB first)
//   frame_len                     payload length in bits, sampled on start
//   start                         begin a frame (honoured only in IDLE)
//   bit_in/bit_valid              serial frame stream
//   busy                          frame in progress
//   done                          one-cycle pulse at check completion
//   crc_ok/crc_err                sticky result of the last frame
//   crc_value                     live working CRC register
module crc_frame_checker #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_poly_data,
  input  logic             cfg_poly_load,
  input  logic             cfg_init_data,
  input  logic             cfg_init_load,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [WIDTH-1:0] crc_value
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   poly_cfg;
  logic [WIDTH-1:0]   init_cfg;
  logic [WIDTH-1:0]   poly_w;
  logic [WIDTH-1:0]   crc;
  logic [WIDTH-1:0]   rx_crc;
  logic [LEN_W-1:0]   len_cnt;
  logic [CNT_W-1:0]   crc_cnt;

  logic               fb;
  logic [WIDTH-1:0]   crc_next;
  logic [WIDTH-1:0]   rx_next;
  logic               match;

  assign fb       = crc[WIDTH-1] ^ bit_in;
  assign crc_next = {crc[WIDTH-2:0], 1'b0}
                  ^ (fb ? poly_w : '0);
  assign rx_next  = {rx_crc[WIDTH-2:0], bit_in};
  assign match    = (rx_next == crc);

  assign busy      = (state != IDLE);
  assign crc_value = crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      poly_cfg <= '0;
      init_cfg <= '0;
      poly_w   <= '0;
      crc      <= '0;
      rx_crc   <= '0;
      len_cnt  <= '0;
      crc_cnt  <= '0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
    end else begin
      done <= 1'b0;

      // Config shifts are independent of the frame: the working
      // polynomial is snapshotted into poly_w at start.
      if (cfg_poly_load)
        poly_cfg <= {poly_cfg[WIDTH-2:0], cfg_poly_data};
      if (cfg_init_load)
        init_cfg <= {init_cfg[WIDTH-2:0], cfg_init_data};

      unique case (state)
        IDLE: begin
          if (start) begin
            crc     <= init_cfg;
            poly_w  <= poly_cfg;
            len_cnt <= frame_len;
            crc_cnt <= '0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
            state   <= (frame_len != '0) ? PAYLOAD : CHECK;
          end
        end
        PAYLOAD: begin
          if (bit_valid) begin
            crc     <= crc_next;
            len_cnt <= len_cnt - 1'b1;
            if (len_cnt == LEN_W'(1))
              state <= CHECK;
          end
        end
        CHECK: begin
          if (bit_valid) begin
            rx_crc  <= rx_next;
            crc_cnt <= crc_cnt + 1'b1;
            if (crc_cnt == LAST) begin
              done    <= 1'b1;
              crc_ok  <= match;
              crc_err <= !match;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker: directed frames plus randomized
// frames scored against a polynomial long-division reference model.
module tb_crc_frame_checker;

  localparam int W  = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_poly_data;
  logic          cfg_poly_load;
  logic          cfg_init_data;
  logic          cfg_init_load;
  logic [LW-1:0] frame_len;
  logic          start;
  logic          bit_in;
  logic          bit_valid;
  logic          busy;
  logic          done;
  logic          crc_ok;
  logic          crc_err;
  logic [W-1:0]  crc_value;

  always #5 clk = ~clk;

  crc_frame_checker #(
    .WIDTH(W),
    .LEN_W(LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_poly_data(cfg_poly_data),
    .cfg_poly_load(cfg_poly_load),
    .cfg_init_data(cfg_init_data),
    .cfg_init_load(cfg_init_load),
    .frame_len    (frame_len),
    .start        (start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done),
    .crc_ok       (crc_ok),
    .crc_err      (crc_err),
    .crc_value    (crc_value)
  );

  int checks = 0;
  int errors = 0;
  bit pay[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Remainder of (init*x^n + M(x)*x^W) mod (x^W + poly), by long division.
  function automatic logic [W-1:0] ref_crc(input logic [W-1:0] p,
                                           input logic [W-1:0] i);
    bit d[$];
    int n;
    logic [W-1:0] r;
    n = pay.size();
    for (int k = 0; k < n; k++) d.push_back(pay[k]);
    for (int k = 0; k < W; k++) d.push_back(1'b0);
    for (int k = 0; k < W; k++) d[k] = d[k] ^ i[W-1-k];
    for (int k = 0; k < n; k++) begin
      if (d[k]) begin
        d[k] = 1'b0;
        for (int j = 0; j < W; j++)
          d[k+1+j] = d[k+1+j] ^ p[W-1-j];
      end
    end
    for (int j = 0; j < W; j++) r[W-1-j] = d[n+j];
    return r;
  endfunction

  task automatic load_cfg(input logic [W-1:0] p, input logic [W-1:0] i);
    for (int b = W - 1; b >= 0; b--) begin
      cfg_poly_load = 1'b1;
      cfg_poly_data = p[b];
      cfg_init_load = 1'b1;
      cfg_init_data = i[b];
      step();
    end
    cfg_poly_load = 1'b0;
    cfg_init_load = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) pay.push_back(v[b]);
  endtask

  task automatic fill_check_str;
    string s;
    s = "123456789";
    pay.delete();
    for (int k = 0; k < s.len(); k++) push_byte(s[k]);
  endtask

  task automatic gap_cycle(input int gap);
    if (gap == 2 && $urandom_range(0, 2) == 0) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  // gap: 0 none, 1 idle cycle after every valid bit, 2 random gaps.
  // disturb: pulse start and reload poly 0x31 mid-payload.
  task automatic run_frame(input string tag,
                           input logic [W-1:0] p,
                           input logic [W-1:0] i,
                           input logic [W-1:0] trailer,
                           input int gap,
                           input bit disturb);
    int n;
    logic [W-1:0] exp_crc;
    logic [7:0] p31;
    bit exp_ok;
    n       = pay.size();
    exp_crc = ref_crc(p, i);
    exp_ok  = (trailer == exp_crc);
    p31     = 8'h31;
    frame_len = LW'(n);
    start     = 1'b1;
    bit_valid = 1'($urandom);
    bit_in    = 1'($urandom);
    step();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_ok_clr"}, {crc_ok, crc_err}, 0);
    for (int k = 0; k < n; k++) begin
      gap_cycle(gap);
      if (disturb && k >= n / 2 && k < n / 2 + 8) begin
        if (k == n / 2) start = 1'b1;
        cfg_poly_load = 1'b1;
        cfg_poly_data = p31[7 - (k - n / 2)];
      end
      bit_valid = 1'b1;
      bit_in    = pay[k];
      step();
      start         = 1'b0;
      cfg_poly_load = 1'b0;
      bit_valid     = 1'b0;
      if (disturb) chk({tag, "_busy_mid"}, busy, 1);
      if (gap == 1) step();
    end
    chk({tag, "_crc_value"}, crc_value, exp_crc);
    for (int k = 0; k < W; k++) begin
      gap_cycle(gap);
      bit_valid = 1'b1;
      bit_in    = trailer[W-1-k];
      step();
      bit_valid = 1'b0;
      if (k < W - 1) begin
        chk({tag, "_no_early_done"}, done, 0);
        if (gap == 1) step();
      end
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_crc_ok"}, crc_ok, exp_ok);
    chk({tag, "_crc_err"}, crc_err, !exp_ok);
    step();
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_sticky"}, {crc_ok, crc_err}, {exp_ok, !exp_ok});
  endtask

  initial begin
    logic [W-1:0] rp, ri, rt, good;
    rst           = 1'b1;
    cfg_poly_data = 1'b0;
    cfg_poly_load = 1'b0;
    cfg_init_data = 1'b0;
    cfg_init_load = 1'b0;
    frame_len     = '0;
    start         = 1'b0;
    bit_in        = 1'b0;
    bit_valid     = 1'b0;
    step();
    step();
    chk("rst_state", {busy, done, crc_ok, crc_err}, 0);
    chk("rst_crc", crc_value, 0);
    rst = 1'b0;
    step();

    // 1: check string, good trailer
    load_cfg(8'h07, 8'h00);
    fill_check_str();
    run_frame("t1", 8'h07, 8'h00, 8'hF4, 0, 1'b0);
    chk("t1_crc_f4", crc_value, 8'hF4);

    // 2: bad trailer, then flipped payload bit
    run_frame("t2a", 8'h07, 8'h00, 8'hF5, 0, 1'b0);
    pay[5] = !pay[5];
    run_frame("t2b", 8'h07, 8'h00, 8'hF4, 0, 1'b0);

    // 3: 8-bit payload with gaps every other cycle
    pay.delete();
    push_byte(8'h01);
    run_frame("t3", 8'h07, 8'h00, 8'h07, 1, 1'b0);

    // start directly after done is accepted
    pay.delete();
    push_byte(8'h01);
    run_frame("t3b", 8'h07, 8'h00, 8'h07, 0, 1'b0);

    // 4: zero-length frame
    load_cfg(8'h07, 8'hAA);
    pay.delete();
    run_frame("t4a", 8'h07, 8'hAA, 8'hAA, 0, 1'b0);
    run_frame("t4b", 8'h07, 8'hAA, 8'hAB, 0, 1'b0);

    // 5: start pulse and poly reload mid-payload
    load_cfg(8'h07, 8'h00);
    fill_check_str();
    run_frame("t5", 8'h07, 8'h00, 8'hF4, 0, 1'b1);
    chk("t5_crc_f4", crc_value, 8'hF4);

    // 6: reset mid-frame
    load_cfg(8'h07, 8'h00);
    fill_check_str();
    frame_len = 8'd72;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bit_valid = 1'b1;
      bit_in    = pay[k];
      step();
    end
    bit_valid = 1'b0;
    chk("t6_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_async_flags", {busy, done, crc_ok, crc_err}, 0);
    chk("t6_async_crc", crc_value, 0);
    step();
    rst = 1'b0;
    step();
    load_cfg(8'h07, 8'h00);
    pay.delete();
    push_byte(8'h01);
    run_frame("t6", 8'h07, 8'h00, 8'h07, 1, 1'b0);

    // randomized frames
    for (int it = 0; it < 30; it++) begin
      rp = W'($urandom);
      ri = W'($urandom);
      load_cfg(rp, ri);
      pay.delete();
      repeat ($urandom_range(0, 40)) pay.push_back(1'($urandom));
      good = ref_crc(rp, ri);
      rt   = good;
      if ($urandom_range(0, 1) == 1)
        rt = good ^ (W'(1) << $urandom_range(0, W - 1));
      run_frame("rnd", rp, ri, rt, 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_checker.md
Name: crc_frame_checker

Overview:
Serial CRC receiver/checker, the receive-side counterpart to the serial CRC calculator.
- Polynomial and init value are loaded serially, MSB first, same scheme as the calculator.
- Accepts a framed serial bit stream: a payload of programmable bit length, then WIDTH received CRC bits, MSB first.
- Computes the CRC over the payload, compares it with the received CRC, and reports pass/fail.

Parameters:
WIDTH, 8, CRC width in bits (>=2).
LEN_W, 8, width of payload bit-length field; max payload is 2^LEN_W-1 bits.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
cfg_poly_data  input  1  serial polynomial bit.
cfg_poly_load  input  1  shift cfg_poly_data into poly config register this cycle.
cfg_init_data  input  1  serial init-value bit.
cfg_init_load  input  1  shift cfg_init_data into init config register this cycle.
frame_len  input  LEN_W  payload length in bits, sampled at start.
start  input  1  begin a frame (honoured only in IDLE).
bit_in  input  1  serial frame bit.
bit_valid  input  1  bit_in is valid this cycle.
busy  output  1  high while a frame is in progress.
done  output  1  one-cycle pulse when a frame check completes.
crc_ok  output  1  last frame's CRC matched; sticky until next accepted start.
crc_err  output  1  last frame's CRC mismatched; sticky until next accepted start.
crc_value  output  WIDTH  working (computed) CRC register, live.

Behaviour:
- Reset: async, active-high. Clears to zero all of the following: state=IDLE, poly_cfg, init_cfg, working poly, crc, rx_crc, counters, busy, done, crc_ok, crc_err, crc_value. Reset mid-frame aborts the frame; no done pulse.
- Config registers:
  - In any state, on cfg_poly_load: poly_cfg <= {poly_cfg[WIDTH-2:0], cfg_poly_data}. Same for init_cfg with cfg_init_load.
  - Both loads may be active in the same cycle; each is independent.
  - Config changes during a frame do not affect that frame.
- FSM states: IDLE, PAYLOAD, CHECK. busy = (state != IDLE).
- IDLE, start=1 (same cycle as the start is accepted):
  - crc <= init_cfg; poly_w <= poly_cfg; len_cnt <= frame_len; crc_cnt <= 0; crc_ok/crc_err <= 0.
  - Next state: PAYLOAD if frame_len != 0, otherwise CHECK.
  - bit_valid in the start cycle is ignored.
- PAYLOAD, on bit_valid:
  - fb = crc[WIDTH-1] ^ bit_in.
  - crc <= {crc[WIDTH-2:0],1'b0} ^ (fb ? poly_w : 0).
  - len_cnt decrements; when len_cnt==1, go to CHECK.
  - No change on cycles with bit_valid=0; gaps of any length are allowed.
- CHECK, on bit_valid:
  - rx_crc <= {rx_crc[WIDTH-2:0], bit_in}; crc_cnt increments.
  - On the WIDTH-th bit (crc_cnt==WIDTH-1), registered at that edge:
    - done=1 for exactly one cycle.
    - crc_ok = ({rx_crc[WIDTH-2:0],bit_in} == crc); crc_err = !crc_ok.
    - State returns to IDLE.
  - Latency: done/crc_ok/crc_err are visible the cycle after the last CRC bit is sampled.
- start while busy: ignored, no effect on the frame.
- start in the cycle directly after done: accepted normally; crc_ok/crc_err clear at that edge.
- crc_ok and crc_err are never both high; both are low from reset until the first completion.
- No final XOR and no bit reflection; MSB-first throughout.

Test Plan:
1. Load poly 0x07, init 0x00; frame_len=72; payload ASCII "123456789" (each byte MSB first), then 0xF4. Required: crc_value=0xF4 at CHECK entry, done pulse, crc_ok=1, crc_err=0.
2. Same as 1 with payload bit 5 inverted, or trailer 0xF5. Required: done pulse, crc_ok=0, crc_err=1.
3. Poly 0x07, init 0x00, frame_len=8, payload 0x01, trailer 0x07, bit_valid low every other cycle. Required: crc_ok=1; done occurs exactly 1 cycle after the 16th valid bit.
4. Init 0xAA, frame_len=0, trailer 0xAA. Required: FSM goes directly to CHECK, crc_ok=1. Repeat with trailer 0xAB. Required: crc_err=1.
5. Pulse start and reload poly to 0x31 mid-PAYLOAD of scenario 1. Required: frame unaffected, crc_ok=1, busy high until done.
6. Assert rst after 20 payload bits. Required: busy/done/crc_ok/crc_err=0 and crc_value=0 immediately, without waiting for a clock edge. Then a fresh scenario 3 frame with config reloaded passes.
